param_dcache: RTL
=================

Name: param_dcache

Overview:
- Parametrised N-way set-associative, write-back, write-allocate data cache between the datapath memory port and the memory controller.
- Successor to the fixed 8-set/2-way/2-word dcache.
- Generalises sets, associativity and block size, and uses true LRU replacement.
- On halt, flushes dirty blocks and raises flushed.

Parameters:
SETS, 8, number of sets; power of 2, >=2
WAYS, 2, associativity; power of 2, >=1
WORDS_PER_BLK, 2, 32-bit words per block; power of 2, >=2

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous active-high reset
halt  in  1  datapath halt request
dmemREN  in  1  datapath read request
dmemWEN  in  1  datapath write request
dmemaddr  in  32  datapath byte address
dmemstore  in  32  datapath write data
dmemload  out  32  read data, valid when dhit=1
dhit  out  1  request serviced this cycle
flushed  out  1  flush complete; sticky until reset
dREN  out  1  memory read request
dWEN  out  1  memory write request
daddr  out  32  memory word address
dstore  out  32  memory write data
dload  in  32  memory read data
dwait  in  1  memory busy; transfer completes in a cycle with dwait=0

Behaviour:
- Clock and reset: single clock CLK; reset RST is asynchronous, active-high.
- Address split, LSB first:
  - [1:0] byte offset, ignored.
  - OB = log2(WORDS_PER_BLK) bits block offset.
  - IB = log2(SETS) bits index.
  - Tag = remaining 30-OB-IB bits.
- Per block state: valid, dirty, tag, data words. Per set: log2(WAYS)-bit age per way (0 = MRU).
- Reset:
  - All valid, dirty and ages cleared; state IDLE.
  - dREN, dWEN, dhit, flushed, daddr, dstore, dmemload all 0.
  - Reset mid-transaction aborts it; partially filled blocks stay invalid.
- Request: exactly one of dmemREN/dmemWEN high. Both high = no-op: dhit=0, no state change.
- IDLE, hit (tag match on a valid way):
  - dhit=1 combinationally in the same cycle.
  - Read: dmemload = addressed word.
  - Write: word updated and dirty set at the next edge.
  - Hit way age -> 0; ways younger than it age +1.
- IDLE, miss:
  - Victim = lowest-index invalid way; otherwise the way with age WAYS-1.
  - Victim dirty -> WB; clean -> FILL.
  - dhit=0 throughout the miss.
- halt in IDLE takes priority over any request -> FLUSH.
- WB:
  - dWEN=1; daddr = {victim tag, idx, word k, 2'b00}; dstore = word k.
  - k runs 0..WORDS_PER_BLK-1 and advances only on dwait=0.
  - After the last word -> FILL.
- FILL:
  - dREN=1; daddr = {request tag, idx, word k, 2'b00}.
  - Word k captured from dload on dwait=0.
  - After the last word: valid=1, dirty=0, tag written -> IDLE. The request then hits on the following cycle.
- While dwait=1: daddr, dstore, dREN and dWEN held stable.
- FLUSH:
  - Walk set 0..SETS-1, way 0..WAYS-1.
  - Dirty block: WORDS_PER_BLK writes as in WB.
  - Clean block: skipped in one cycle with no memory request.
  - Every block invalidated and cleaned.
  - After the final block -> CNT (feature on) or DONE.
- DONE: flushed=1, no memory requests, requests ignored (dhit=0) until reset.
- Counters and indices sized from the parameters; wrap-around never occurs within a walk.

Optional Feature:
- Macro: DCACHE_HIT_COUNTER_EN.
- When defined:
  - 32-bit hit counter increments on each cycle with dhit=1 whose access was not preceded by a miss for that same request; saturates at 0xFFFFFFFF.
  - CNT state after FLUSH: dWEN=1, daddr=0x00003100, dstore=count; on dwait=0 -> DONE.
- When undefined: no counter and no CNT state; FLUSH goes directly to DONE.

Test Plan:
1. Cold read of 0x40 (defaults), memory returns 0x11 at 0x40 and 0x22 at 0x44:
   - dREN to 0x40 then 0x44.
   - Next cycle dhit=1, dmemload=0x11.
   - Read 0x44 -> dhit=1, 0x22, no dREN.
2. After test 1, write 0xAB to 0x44 (hit, dirty); read 0x80 (fills way1); read 0xC0:
   - Evicts tag 1.
   - dWEN 0x40/0x11, then 0x44/0xAB.
   - Then dREN 0xC0, 0xC4.
3. WAYS=4, same set, read tags 1,2,3,4; re-read tag 1; read tag 5:
   - Tag 2's block replaced.
   - Tags 1,3,4 still hit.
4. Hold dwait=1 for 5 cycles during FILL word 0:
   - daddr/dREN stable for all 5 cycles.
   - No capture; fill completes normally afterwards.
5. One dirty block (set 3, way 1), then halt:
   - Exactly WORDS_PER_BLK writes at that block's addresses.
   - flushed=1 and stays high.
   - With DCACHE_HIT_COUNTER_EN: one extra write to 0x3100 with the hit count.
6. Assert RST during WB word 0:
   - Same cycle: dWEN=0.
   - After release, a read of the old address misses (dREN issued).

Source files
------------

// File: rtl/param_dcache.sv
// Parametrised N-way set-associative write-back/write-allocate data cache with true-LRU
// replacement and flush-on-halt. Optional hit counter dumped after flush: DCACHE_HIT_COUNTER_EN.
module param_dcache #(
  parameter int SETS          = 8,
  parameter int WAYS          = 2,
  parameter int WORDS_PER_BLK = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        halt,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic [31:0] dmemload,
  output logic        dhit,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic [31:0] dload,
  input  logic        dwait
);

  localparam int OB = $clog2(WORDS_PER_BLK);
  localparam int IB = $clog2(SETS);
  localparam int TB = 30 - OB - IB;
  localparam int AW = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [OB-1:0] LAST_WORD = OB'(WORDS_PER_BLK - 1);
  localparam logic [IB-1:0] LAST_SET  = IB'(SETS - 1);
  localparam logic [AW-1:0] LAST_WAY  = AW'(WAYS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB,
    S_FILL,
    S_FLUSH,
`ifdef DCACHE_HIT_COUNTER_EN
    S_CNT,
`endif
    S_DONE
  } state_e;

  logic          valid_q [SETS][WAYS];
  logic          dirty_q [SETS][WAYS];
  logic [AW-1:0] age_q   [SETS][WAYS];
  logic [TB-1:0] tag_q   [SETS][WAYS];
  logic [31:0]   data_q  [SETS][WAYS][WORDS_PER_BLK];

  state_e        state_q, state_d;
  logic [OB-1:0] word_q, word_d;
  logic [AW-1:0] victim_q, victim_d;
  logic [IB-1:0] req_idx_q, req_idx_d;
  logic [TB-1:0] req_tag_q, req_tag_d;
  logic [IB-1:0] fl_set_q, fl_set_d;
  logic [AW-1:0] fl_way_q, fl_way_d;

  logic [OB-1:0] req_word;
  logic [IB-1:0] req_idx;
  logic [TB-1:0] req_tag;
  logic          unused_byte_off;

  assign req_word        = dmemaddr[2 +: OB];
  assign req_idx         = dmemaddr[2 + OB +: IB];
  assign req_tag         = dmemaddr[31 -: TB];
  assign unused_byte_off = ^dmemaddr[1:0];

  logic          hit_any, inv_any;
  logic [AW-1:0] hit_way, inv_way, old_way, old_age, victim;
  logic [AW-1:0] hit_age;
  logic          idle_req, miss;

  // NOTE: every variable written in an always_comb gets a default first, so no path leaves it
  // holding its old value and no latch is inferred.
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    old_way = '0;
    old_age = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit_any && valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
        hit_any = 1'b1;
        hit_way = AW'(w);
      end
      if (!inv_any && !valid_q[req_idx][w]) begin
        inv_any = 1'b1;
        inv_way = AW'(w);
      end
      if (age_q[req_idx][w] > old_age) begin
        old_age = age_q[req_idx][w];
        old_way = AW'(w);
      end
    end
    victim = inv_any ? inv_way : old_way;
  end

  assign hit_age  = age_q[req_idx][hit_way];
  assign idle_req = (state_q == S_IDLE) && !halt && (dmemREN ^ dmemWEN);
  assign dhit     = idle_req && hit_any;
  assign miss     = idle_req && !hit_any;
  assign dmemload = (dhit && dmemREN) ? data_q[req_idx][hit_way][req_word] : '0;
  assign flushed  = (state_q == S_DONE);

`ifdef DCACHE_HIT_COUNTER_EN
  logic [31:0] hit_cnt_q;
  logic        miss_pend_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hit_cnt_q   <= '0;
      miss_pend_q <= 1'b0;
    end else begin
      if (miss)      miss_pend_q <= 1'b1;
      else if (dhit) miss_pend_q <= 1'b0;
      if (dhit && !miss_pend_q && hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 32'd1;
    end
  end
`endif

  logic fill_beat, fill_last, fl_blk_done, fl_dirty;

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    victim_d    = victim_q;
    req_idx_d   = req_idx_q;
    req_tag_d   = req_tag_q;
    fl_set_d    = fl_set_q;
    fl_way_d    = fl_way_q;
    dREN        = 1'b0;
    dWEN        = 1'b0;
    daddr       = '0;
    dstore      = '0;
    fill_beat   = 1'b0;
    fill_last   = 1'b0;
    fl_blk_done = 1'b0;
    fl_dirty    = dirty_q[fl_set_q][fl_way_q];
    case (state_q)
      S_IDLE: begin
        if (halt) begin
          state_d  = S_FLUSH;
          fl_set_d = '0;
          fl_way_d = '0;
          word_d   = '0;
        end else if (miss) begin
          victim_d  = victim;
          req_idx_d = req_idx;
          req_tag_d = req_tag;
          word_d    = '0;
          state_d   = dirty_q[req_idx][victim] ? S_WB : S_FILL;
        end
      end
      S_WB: begin
        dWEN   = 1'b1;
        daddr  = {tag_q[req_idx_q][victim_q], req_idx_q, word_q, 2'b00};
        dstore = data_q[req_idx_q][victim_q][word_q];
        if (!dwait) begin
          word_d = word_q + 1'b1;
          if (word_q == LAST_WORD) state_d = S_FILL;
        end
      end
      S_FILL: begin
        dREN      = 1'b1;
        daddr     = {req_tag_q, req_idx_q, word_q, 2'b00};
        fill_beat = !dwait;
        if (!dwait) begin
          word_d = word_q + 1'b1;
          if (word_q == LAST_WORD) begin
            fill_last = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end
      S_FLUSH: begin
        if (fl_dirty) begin
          dWEN   = 1'b1;
          daddr  = {tag_q[fl_set_q][fl_way_q], fl_set_q, word_q, 2'b00};
          dstore = data_q[fl_set_q][fl_way_q][word_q];
          if (!dwait) begin
            word_d      = word_q + 1'b1;
            fl_blk_done = (word_q == LAST_WORD);
          end
        end else begin
          fl_blk_done = 1'b1;
        end
        if (fl_blk_done) begin
          if (fl_way_q == LAST_WAY) begin
            fl_way_d = '0;
            if (fl_set_q == LAST_SET) begin
`ifdef DCACHE_HIT_COUNTER_EN
              state_d = S_CNT;
`else
              state_d = S_DONE;
`endif
            end else begin
              fl_set_d = fl_set_q + 1'b1;
            end
          end else begin
            fl_way_d = fl_way_q + 1'b1;
          end
        end
      end
`ifdef DCACHE_HIT_COUNTER_EN
      S_CNT: begin
        dWEN   = 1'b1;
        daddr  = 32'h0000_3100;
        dstore = hit_cnt_q;
        if (!dwait) state_d = S_DONE;
      end
`endif
      S_DONE:  ;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      word_q    <= '0;
      victim_q  <= '0;
      req_idx_q <= '0;
      req_tag_q <= '0;
      fl_set_q  <= '0;
      fl_way_q  <= '0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      victim_q  <= victim_d;
      req_idx_q <= req_idx_d;
      req_tag_q <= req_tag_d;
      fl_set_q  <= fl_set_d;
      fl_way_q  <= fl_way_d;
    end
  end

  // Ages start tied at 0; bumping every other way at or below the hit age breaks ties
  // while keeping a distinct-age set a strict LRU permutation.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          age_q[s][w]   <= '0;
        end
      end
    end else begin
      if (dhit) begin
        if (dmemWEN) dirty_q[req_idx][hit_way] <= 1'b1;
        for (int w = 0; w < WAYS; w++) begin
          if (AW'(w) == hit_way)                  age_q[req_idx][w] <= '0;
          else if (age_q[req_idx][w] <= hit_age)  age_q[req_idx][w] <= age_q[req_idx][w] + AW'(1);
        end
      end
      if (miss) begin
        valid_q[req_idx][victim] <= 1'b0;
        dirty_q[req_idx][victim] <= 1'b0;
      end
      if (fill_last) valid_q[req_idx_q][victim_q] <= 1'b1;
      if (fl_blk_done) begin
        valid_q[fl_set_q][fl_way_q] <= 1'b0;
        dirty_q[fl_set_q][fl_way_q] <= 1'b0;
      end
    end
  end

  // NOTE: tag and data arrays are deliberately left out of reset; the cleared valid bits
  // make their contents irrelevant and keep them plain RAM.
  always_ff @(posedge CLK) begin
    if (dhit && dmemWEN) data_q[req_idx][hit_way][req_word] <= dmemstore;
    if (fill_beat)       data_q[req_idx_q][victim_q][word_q] <= dload;
    if (fill_last)       tag_q[req_idx_q][victim_q] <= req_tag_q;
  end

endmodule
